dma_stream_fifo: RTL

Elastic AXI-stream buffer between the DMA's stream source and the FIR/MM engine's stream sink. It decouples the DMA's bursty SDRAM-paced beats from the accelerator's input rate. It carries data and tlast, reports occupancy and almost-full, and supports a synchronous flush for mode switches (tap load / FIR / MM). The same module is instanced on the return path (engine `sm_*` to DMA).

---
 rtl/dma_stream_fifo.sv | 106 ++++++++++
 1 files changed

// File: rtl/dma_stream_fifo.sv
// Elastic first-word-fall-through AXI-stream FIFO carrying data and tlast, with occupancy,
// almost-full and synchronous flush. Define DMA_STREAM_FIFO_STATS_EN to add hwm/pkt_cnt outputs.
module dma_stream_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_tvalid,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
`ifdef DMA_STREAM_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm,
  output logic [15:0]              pkt_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W:0]   w_rd_entry;
  logic              w_push;
  logic              w_pop;

  assign s_tready    = (r_count != CW'(DEPTH));
  assign m_tvalid    = (r_count != '0);
  assign w_push      = s_tvalid & s_tready;
  assign w_pop       = m_tvalid & m_tready;
  assign w_rd_entry  = r_mem[r_rd_ptr];
  assign m_tdata     = w_rd_entry[DATA_W-1:0];
  assign m_tlast     = w_rd_entry[DATA_W] & m_tvalid;
  assign count       = r_count;
  assign almost_full = (r_count >= CW'(AFULL_THRESH));

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // NOTE: storage has no reset; contents are only observable once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

`ifdef DMA_STREAM_FIFO_STATS_EN
  logic [CW-1:0] r_hwm;
  logic [15:0]   r_pkt_cnt;

  assign hwm     = r_hwm;
  assign pkt_cnt = r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm     <= '0;
      r_pkt_cnt <= '0;
    end else if (flush) begin
      r_hwm     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
      if (w_pop && m_tlast)    r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end
`endif

endmodule
